// File: rtl/cpu_exec_ctrl_pkg.sv
// Shared encodings for the CPU run/halt sequencer: FSM state codes and
// halt-cause codes, both as seen on the 2-bit state/haltCause outputs.
package exec_ctrl_pkg;

  localparam logic [1:0] ST_RESET = 2'd0;
  localparam logic [1:0] ST_HALT  = 2'd1;
  localparam logic [1:0] ST_RUN   = 2'd2;
  localparam logic [1:0] ST_STEP  = 2'd3;

  localparam logic [1:0] CAUSE_NONE = 2'd0;
  localparam logic [1:0] CAUSE_STOP = 2'd1;
  localparam logic [1:0] CAUSE_HLT  = 2'd2;
  localparam logic [1:0] CAUSE_BP   = 2'd3;

endpackage

// File: rtl/cpu_exec_ctrl_if.sv
// Bundle of the sequencer's control, CPU-facing and status signals.
// master = the sequencer itself, slave = clock control / debug / CPU side.
interface cpu_exec_ctrl_if #(
  parameter int PC_W  = 8,
  parameter int CNT_W = 16
);

  logic             ceIn;
  logic             runReq;
  logic             stopReq;
  logic             stepReq;
  logic             cpuRstReq;
  logic             haltIn;
  logic [PC_W-1:0]  pc;
  logic             bpEn;
  logic [PC_W-1:0]  bpAddr;
  logic             cpuCe;
  logic             cpuRst;
  logic [1:0]       state;
  logic [1:0]       haltCause;
  logic [CNT_W-1:0] cycleCnt;

  modport master (
    input  ceIn, runReq, stopReq, stepReq, cpuRstReq, haltIn, pc, bpEn, bpAddr,
    output cpuCe, cpuRst, state, haltCause, cycleCnt
  );

  modport slave (
    output ceIn, runReq, stopReq, stepReq, cpuRstReq, haltIn, pc, bpEn, bpAddr,
    input  cpuCe, cpuRst, state, haltCause, cycleCnt
  );

endinterface

// File: rtl/cpu_exec_ctrl_sat_counter.sv
// Saturating up-counter: increments on inc, holds at all-ones, clr wins.
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rstN,
  input  logic         inc,
  input  logic         clr,
  output logic [W-1:0] value
);

  // Count up on inc, stick at all-ones, synchronous clear has priority.
  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      value <= '0;
    end else if (clr) begin
      value <= '0;
    end else if (inc && (value != {W{1'b1}})) begin
      value <= value + W'(1);
    end
  end

endmodule

// File: rtl/cpu_exec_ctrl.sv
// Run/halt sequencer between the clock-enable generator and the CPU core.
// Gates ceIn into cpuCe, sequences a timed CPU reset, halts on stop / HLT /
// breakpoint, and supports run, resume and single-step.
module cpu_exec_ctrl
  import exec_ctrl_pkg::*;
#(
  parameter int PC_W       = 8,
  parameter int CNT_W      = 16,
  parameter int RST_CYCLES = 16,
  parameter int AUTO_RUN   = 0
) (
  input logic             clk,
  input logic             rstN,
  cpu_exec_ctrl_if.master bus
);

  localparam int RC_W = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;
  localparam logic [RC_W-1:0] RC_LAST = RC_W'(RST_CYCLES - 1);
  localparam logic [1:0] ST_AFTER_RST = (AUTO_RUN != 0) ? ST_RUN : ST_HALT;

  logic [1:0]       stateQ, stateD;
  logic [1:0]       causeQ, causeD;
  logic [RC_W-1:0]  rstCntQ, rstCntD;
  logic             bpSkipQ, bpSkipD;
  logic             cpuRstQ;
  logic             bpHit;
  logic             cpuCe;
  logic [CNT_W-1:0] cycleCnt;

  // Breakpoint match, masked for the first instruction after a resume.
  always_comb begin
    bpHit = bus.bpEn & (bus.pc == bus.bpAddr) & ~bpSkipQ;
  end

  // Gated CPU clock enable; zero latency relative to ceIn.
  always_comb begin
    cpuCe = 1'b0;
    case (stateQ)
      ST_RUN:  cpuCe = bus.ceIn & ~bus.haltIn & ~bpHit & ~bus.stopReq;
      ST_STEP: cpuCe = bus.ceIn;
      default: cpuCe = 1'b0;
    endcase
  end

  // Next-state, reset-sequence counter, halt cause and breakpoint skip.
  always_comb begin
    stateD  = stateQ;
    causeD  = causeQ;
    rstCntD = rstCntQ;
    bpSkipD = bpSkipQ;
    if (bus.cpuRstReq) begin
      stateD  = ST_RESET;
      causeD  = CAUSE_NONE;
      rstCntD = '0;
      bpSkipD = 1'b0;
    end else begin
      // The breakpoint instruction has now executed; re-arm the match.
      if (cpuCe) bpSkipD = 1'b0;
      case (stateQ)
        ST_RESET: begin
          if (rstCntQ == RC_LAST) stateD = ST_AFTER_RST;
          else                    rstCntD = rstCntQ + RC_W'(1);
        end
        ST_RUN: begin
          if (bus.stopReq) begin
            stateD = ST_HALT;
            causeD = CAUSE_STOP;
          end else if (bus.ceIn && bus.haltIn) begin
            stateD = ST_HALT;
            causeD = CAUSE_HLT;
          end else if (bus.ceIn && bpHit) begin
            stateD = ST_HALT;
            causeD = CAUSE_BP;
          end
        end
        ST_HALT: begin
          // A halted CPU (HLT level) cannot be resumed or stepped.
          if (!bus.stopReq && !bus.haltIn) begin
            if (bus.runReq) begin
              stateD  = ST_RUN;
              bpSkipD = 1'b1;
            end else if (bus.stepReq) begin
              stateD  = ST_STEP;
              bpSkipD = 1'b1;
            end
          end
        end
        ST_STEP: begin
          if (bus.ceIn) begin
            stateD = ST_HALT;
            causeD = CAUSE_STOP;
          end
        end
        default: stateD = ST_RESET;
      endcase
    end
  end

  // Control registers; cpuRst is registered from the next state.
  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      stateQ  <= ST_RESET;
      causeQ  <= CAUSE_NONE;
      rstCntQ <= '0;
      bpSkipQ <= 1'b0;
      cpuRstQ <= 1'b1;
    end else begin
      stateQ  <= stateD;
      causeQ  <= causeD;
      rstCntQ <= rstCntD;
      bpSkipQ <= bpSkipD;
      cpuRstQ <= (stateD == ST_RESET);
    end
  end

  sat_counter #(.W(CNT_W)) uCycleCnt (
    .clk   (clk),
    .rstN  (rstN),
    .inc   (cpuCe),
    .clr   (bus.cpuRstReq),
    .value (cycleCnt)
  );

  assign bus.cpuCe     = cpuCe;
  assign bus.cpuRst    = cpuRstQ;
  assign bus.state     = stateQ;
  assign bus.haltCause = causeQ;
  assign bus.cycleCnt  = cycleCnt;

endmodule

// File: tb/tb_cpu_exec_ctrl.sv
// Scoreboard bench for cpu_exec_ctrl: directed scenarios then random traffic.
// Two DUTs share stimulus: one with a 16-bit cycle counter, one with 4 bits.
module tb_cpu_exec_ctrl;

  localparam int RSTC = 16;
  localparam int M_RESET = 0, M_HALT = 1, M_RUN = 2, M_STEP = 3;
  localparam int C_NONE = 0, C_STOP = 1, C_HLT = 2, C_BP = 3;

  typedef struct {
    bit ce;
    bit rst;
    int st;
    int cause;
    int cnt;
  } exp_t;

  logic clk;
  logic rstN;
  logic ceIn, runReq, stopReq, stepReq, cpuRstReq, haltIn, bpEn;
  logic [7:0] pc, bpAddr;

  exp_t q[$];
  int checks = 0;
  int failures = 0;
  int cyc = 0;

  // Stimulus-side globals
  bit rstNv = 0;
  bit haltLvl = 0;
  bit bpEnV = 0;
  logic [7:0] bpAddrV = 8'h10;
  logic [7:0] pcReg = 8'h00;

  // Reference model
  int mSt = M_RESET;
  int mLeft = RSTC;
  int mCause = C_NONE;
  int mCnt = 0;
  bit mSkip = 0;

  cpu_exec_ctrl_if #(.PC_W(8), .CNT_W(16)) ifA ();
  cpu_exec_ctrl_if #(.PC_W(8), .CNT_W(4))  ifB ();

  assign ifA.ceIn = ceIn;       assign ifB.ceIn = ceIn;
  assign ifA.runReq = runReq;   assign ifB.runReq = runReq;
  assign ifA.stopReq = stopReq; assign ifB.stopReq = stopReq;
  assign ifA.stepReq = stepReq; assign ifB.stepReq = stepReq;
  assign ifA.cpuRstReq = cpuRstReq; assign ifB.cpuRstReq = cpuRstReq;
  assign ifA.haltIn = haltIn;   assign ifB.haltIn = haltIn;
  assign ifA.pc = pc;           assign ifB.pc = pc;
  assign ifA.bpEn = bpEn;       assign ifB.bpEn = bpEn;
  assign ifA.bpAddr = bpAddr;   assign ifB.bpAddr = bpAddr;

  cpu_exec_ctrl #(.PC_W(8), .CNT_W(16), .RST_CYCLES(RSTC), .AUTO_RUN(0)) dutA (
    .clk(clk), .rstN(rstN), .bus(ifA.master));
  cpu_exec_ctrl #(.PC_W(8), .CNT_W(4), .RST_CYCLES(RSTC), .AUTO_RUN(0)) dutB (
    .clk(clk), .rstN(rstN), .bus(ifB.master));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] got, input int exp);
    checks++;
    if (got !== 32'(exp)) begin
      failures++;
      $display("FAIL %s cycle=%0d got=%0d expected=%0d", nm, cyc, got, exp);
    end
  endtask

  // Monitor: every cycle the DUT presents outputs; compare against queue head.
  always @(negedge clk) begin
    exp_t e;
    if (q.size() > 0) begin
      e = q.pop_front();
      chk("cpuCe",      32'(ifA.cpuCe), int'(e.ce));
      chk("cpuRst",     32'(ifA.cpuRst), int'(e.rst));
      chk("state",      32'(ifA.state), e.st);
      chk("haltCause",  32'(ifA.haltCause), e.cause);
      chk("cycleCnt16", 32'(ifA.cycleCnt), (e.cnt > 65535) ? 65535 : e.cnt);
      chk("cpuCe_b",    32'(ifB.cpuCe), int'(e.ce));
      chk("cycleCnt4",  32'(ifB.cycleCnt), (e.cnt > 15) ? 15 : e.cnt);
      cyc++;
    end
  end

  // One clock of stimulus: apply inputs, push the model's expected outputs,
  // then advance the model across the coming edge.
  task automatic drive(input bit ce, input bit run, input bit stop,
                       input bit step, input bit rr);
    exp_t e;
    bit hit, ceOut;
    @(posedge clk); #1;
    rstN = rstNv; ceIn = ce; runReq = run; stopReq = stop; stepReq = step;
    cpuRstReq = rr; haltIn = haltLvl; pc = pcReg; bpEn = bpEnV; bpAddr = bpAddrV;
    if (!rstNv) begin
      mSt = M_RESET; mLeft = RSTC; mCause = C_NONE; mCnt = 0; mSkip = 0;
    end
    hit = bpEnV && (pcReg == bpAddrV) && !mSkip;
    if (mSt == M_RUN)       ceOut = ce && !haltLvl && !hit && !stop;
    else if (mSt == M_STEP) ceOut = ce;
    else                    ceOut = 0;
    e.ce = ceOut; e.rst = (mSt == M_RESET); e.st = mSt;
    e.cause = mCause; e.cnt = mCnt;
    q.push_back(e);
    if (rstNv) begin
      if (rr) begin
        mSt = M_RESET; mLeft = RSTC; mCause = C_NONE; mCnt = 0; mSkip = 0;
      end else begin
        if (ceOut) begin
          mCnt++;
          mSkip = 0;
        end
        if (mSt == M_RESET) begin
          if (mLeft == 1) mSt = M_HALT;
          else mLeft--;
        end else if (mSt == M_RUN) begin
          if (stop) begin mSt = M_HALT; mCause = C_STOP; end
          else if (ce && haltLvl) begin mSt = M_HALT; mCause = C_HLT; end
          else if (ce && hit) begin mSt = M_HALT; mCause = C_BP; end
        end else if (mSt == M_HALT) begin
          if (!stop && !haltLvl && run) begin mSt = M_RUN; mSkip = 1; end
          else if (!stop && !haltLvl && step) begin mSt = M_STEP; mSkip = 1; end
        end else begin
          if (ce) begin mSt = M_HALT; mCause = C_STOP; end
        end
      end
    end
    if (ceOut) pcReg = pcReg + 8'd1;
  endtask

  task automatic idle(input int n, input bit withCe);
    for (int i = 0; i < n; i++) drive(withCe && (i % 2 == 1), 0, 0, 0, 0);
  endtask

  initial begin
    rstN = 0; ceIn = 0; runReq = 0; stopReq = 0; stepReq = 0; cpuRstReq = 0;
    haltIn = 0; pc = 0; bpEn = 0; bpAddr = 0;

    // Reset, then reset sequence with ceIn pulses that must be blocked
    rstNv = 0;
    idle(3, 1);
    rstNv = 1;
    idle(24, 1);

    // Run five cycles, then stop coincident with ceIn
    drive(0, 1, 0, 0, 0);
    for (int i = 0; i < 5; i++) begin drive(1, 0, 0, 0, 0); drive(0, 0, 0, 0, 0); end
    drive(1, 0, 1, 0, 0);
    idle(4, 1);

    // Breakpoint at 0x10: halt, resume through it, hit it again
    bpEnV = 1; bpAddrV = 8'h10; pcReg = 8'h0E;
    drive(0, 1, 0, 0, 0);
    for (int i = 0; i < 4; i++) begin drive(1, 0, 0, 0, 0); drive(0, 0, 0, 0, 0); end
    drive(0, 1, 0, 0, 0);
    drive(1, 0, 0, 0, 0);
    pcReg = 8'h0F;
    for (int i = 0; i < 4; i++) begin drive(1, 0, 0, 0, 0); drive(0, 0, 0, 0, 0); end
    bpEnV = 0;

    // HLT: halt, ignored run/step, then CPU reset request
    drive(0, 1, 0, 0, 0);
    drive(1, 0, 0, 0, 0);
    haltLvl = 1;
    drive(1, 0, 0, 0, 0);
    drive(0, 1, 0, 0, 0);
    drive(1, 0, 0, 0, 0);
    drive(0, 0, 0, 1, 0);
    drive(1, 0, 0, 0, 0);
    drive(0, 0, 0, 0, 1);
    haltLvl = 0;
    idle(20, 1);

    // Single step with ceIn in the request cycle, then run+stop together
    drive(1, 0, 0, 1, 0);
    drive(0, 0, 0, 0, 0);
    drive(1, 0, 0, 0, 0);
    idle(3, 1);
    drive(1, 1, 1, 0, 0);
    idle(3, 1);

    // Saturation of the 4-bit counter, then reset request mid-RESET
    drive(0, 1, 0, 0, 0);
    for (int i = 0; i < 20; i++) begin drive(1, 0, 0, 0, 0); drive(0, 0, 0, 0, 0); end
    drive(0, 0, 0, 0, 1);
    idle(5, 1);
    drive(0, 0, 0, 0, 1);
    idle(22, 1);

    // Random traffic
    for (int n = 0; n < 3000; n++) begin
      bit rr;
      if (!haltLvl && $urandom_range(0, 199) == 0) haltLvl = 1;
      rr = ($urandom_range(0, 149) == 0) || (haltLvl && $urandom_range(0, 24) == 0);
      if ($urandom_range(0, 99) == 0) bpEnV = ~bpEnV;
      if ($urandom_range(0, 199) == 0) bpAddrV = 8'($urandom_range(8, 24));
      if ($urandom_range(0, 49) == 0) pcReg = 8'($urandom_range(0, 31));
      if (pcReg > 8'h1F) pcReg = 8'h00;
      drive(bit'($urandom_range(0, 1)),
            $urandom_range(0, 9) == 0,
            $urandom_range(0, 19) == 0,
            $urandom_range(0, 11) == 0,
            rr);
      if (rr) haltLvl = 0;
    end

    repeat (2) @(posedge clk);
    checks++;
    if (q.size() != 0) begin
      failures++;
      $display("FAIL scoreboard_drain left=%0d expected=0", q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
